// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS boot-time program loader.
// WORD_ADDR_SHIFT is shared with the PC logic, so word/byte address scaling stays consistent.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int LEN_BYTES       = 2;
    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;
    localparam int LEN_WIDTH       = LEN_BYTES * 8;

    function automatic logic [31:0] wordToByteAddr(input logic [LEN_WIDTH-1:0] wordIndex);
        return 32'(wordIndex) << WORD_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/mips_program_loader_byte_packer.sv
// Big-endian byte-to-word packer: bytes shift in at the low lane, so the first
// byte of a word ends up in bits 31:24 after four shifts.
module byte_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shiftEn,
    input  logic [7:0]  byteIn,
    output logic [31:0] nextWord,
    output logic        wordFull
);

    logic [31:0] packedWord;
    logic [1:0]  byteCountReg;

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : gen_lane
            logic [7:0] laneReg;

            if (gi == 0) begin : gen_first
                always_ff @(posedge clk) begin
                    if (reset || clear) begin
                        laneReg <= 8'h00;
                    end else if (shiftEn) begin
                        laneReg <= byteIn;
                    end
                end
            end else begin : gen_rest
                always_ff @(posedge clk) begin
                    if (reset || clear) begin
                        laneReg <= 8'h00;
                    end else if (shiftEn) begin
                        laneReg <= packedWord[(gi-1)*8 +: 8];
                    end
                end
            end

            assign packedWord[gi*8 +: 8] = laneReg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byteCountReg <= 2'd0;
        end else if (shiftEn) begin
            byteCountReg <= byteCountReg + 2'd1;
        end
    end

    // Asserted while three bytes are held: the next shifted byte completes the word.
    assign wordFull = (byteCountReg == 2'(BYTES_PER_WORD - 1));
    assign nextWord = {packedWord[23:0], byteIn};

endmodule

// File: rtl/mips_program_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes big-endian words into
// instruction memory and holds the core in reset until the whole image is written.
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 54
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    loader_state_t        stateReg, stateNext;
    logic [LEN_WIDTH-1:0] lenReg, lenNext;
    logic [LEN_WIDTH-1:0] indexReg, indexNext;
    logic [LEN_WIDTH-1:0] lenCandidate;

    logic        byteReadyReg;
    logic        imemWeReg;
    logic [31:0] imemAddrReg;
    logic [31:0] imemWdataReg;
    logic        cpuResetReg;
    logic        doneReg;
    logic        errorReg;

    logic        xfer;
    logic        shiftEn;
    logic        packClear;
    logic        captureWord;
    logic        wordFull;
    logic [31:0] nextWord;

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (packClear),
        .shiftEn  (shiftEn),
        .byteIn   (byte_in),
        .nextWord (nextWord),
        .wordFull (wordFull)
    );

    // byteReadyReg mirrors the registered state, so it is safe to qualify transfers with it.
    assign xfer         = byte_valid & byteReadyReg;
    assign lenCandidate = {lenReg[15:8], byte_in};

    always_comb begin
        stateNext   = stateReg;
        lenNext     = lenReg;
        indexNext   = indexReg;
        shiftEn     = 1'b0;
        packClear   = 1'b0;
        captureWord = 1'b0;

        case (stateReg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    stateNext = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    lenNext[15:8] = byte_in;
                    stateNext     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    lenNext = lenCandidate;
                    if (lenCandidate == '0 || lenCandidate > LEN_WIDTH'(MEMORY_DEPTH)) begin
                        stateNext = S_ERROR;
                    end else begin
                        stateNext = S_DATA;
                        indexNext = '0;
                        packClear = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shiftEn = 1'b1;
                    if (wordFull) begin
                        captureWord = 1'b1;
                        stateNext   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                indexNext = indexReg + 1'b1;
                stateNext = (indexNext == lenReg) ? S_DONE : S_DATA;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with stateReg.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= S_IDLE;
            lenReg       <= '0;
            indexReg     <= '0;
            byteReadyReg <= 1'b0;
            imemWeReg    <= 1'b0;
            imemAddrReg  <= 32'h0;
            imemWdataReg <= 32'h0;
            cpuResetReg  <= 1'b1;
            doneReg      <= 1'b0;
            errorReg     <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            lenReg       <= lenNext;
            indexReg     <= indexNext;
            byteReadyReg <= (stateNext == S_LEN_HI) || (stateNext == S_LEN_LO) ||
                            (stateNext == S_DATA);
            imemWeReg    <= (stateNext == S_WRITE);
            cpuResetReg  <= (stateNext != S_DONE);
            doneReg      <= (stateNext == S_DONE);
            errorReg     <= (stateNext == S_ERROR);
            if (captureWord) begin
                imemAddrReg  <= wordToByteAddr(indexReg);
                imemWdataReg <= nextWord;
            end
        end
    end

    assign byte_ready = byteReadyReg;
    assign imem_we    = imemWeReg;
    assign imem_addr  = imemAddrReg;
    assign imem_wdata = imemWdataReg;
    assign cpu_reset  = cpuResetReg;
    assign done       = doneReg;
    assign error      = errorReg;

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: expected writes are queued as bytes are
// driven and popped by a monitor whenever imem_we is seen.
module tb_mips_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCnt   = 0;
    int startCnt   = 0;
    int lastWeCnt  = 0;
    int writeCount = 0;
    logic [31:0] lastAddr = 32'h0;
    int expIndex   = 0;
    logic [63:0] sbQueue[$];

    mips_program_loader #(.MEMORY_DEPTH(54)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [63:0] e;
            $display("write addr=%h data=%h", imem_addr, imem_wdata);
            lastWeCnt = cycleCnt;
            lastAddr  = imem_addr;
            writeCount++;
            checkVal("ready_in_write", 32'(byte_ready), 32'd0);
            if (sbQueue.size() == 0) begin
                checkVal("spurious_we", 32'(imem_we), 32'd0);
            end else begin
                e = sbQueue.pop_front();
                checkVal("wr_addr", imem_addr, e[63:32]);
                checkVal("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic checkReset(input string tag);
        checkVal({tag, "_ready"}, 32'(byte_ready), 32'd0);
        checkVal({tag, "_we"},    32'(imem_we),    32'd0);
        checkVal({tag, "_addr"},  imem_addr,       32'd0);
        checkVal({tag, "_wdata"}, imem_wdata,      32'd0);
        checkVal({tag, "_cpurst"},32'(cpu_reset),  32'd1);
        checkVal({tag, "_done"},  32'(done),       32'd0);
        checkVal({tag, "_error"}, 32'(error),      32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic sendByte(input logic [7:0] b, input bit gap);
        int t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            checkVal("ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        startCnt = cycleCnt;
        expIndex = 0;
    endtask

    task automatic sendHeader(input logic [15:0] len, input bit gap);
        sendByte(len[15:8], gap);
        sendByte(len[7:0], gap);
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gap);
        sbQueue.push_back({32'(expIndex) * 32'd4, w});
        expIndex++;
        for (int i = 0; i < 4; i++) begin
            sendByte(w[31-8*i -: 8], gap);
        end
    endtask

    task automatic waitDone(input string tag, input int expCycles);
        int t = 0;
        while (!done && !error && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkVal({tag, "_done"}, 32'(done), 32'd1);
        checkVal({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
        checkVal({tag, "_rst_fall"}, 32'(cycleCnt - lastWeCnt), 32'd1);
        if (expCycles > 0) begin
            checkVal({tag, "_cycles"}, 32'(cycleCnt - startCnt), 32'(expCycles));
        end
    endtask

    initial begin
        int wBefore;
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("por");
        reset = 1'b0;
        @(negedge clk);

        // Reset and start together: reset wins, loader stays idle.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal("rst_start_ready", 32'(byte_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkVal("rst_start_idle", 32'(byte_ready), 32'd0);

        // Nominal two-word image with valid held high.
        pulseStart();
        checkVal("nom_cpurst_load", 32'(cpu_reset), 32'd1);
        sendHeader(16'd2, 1'b0);
        sendWord(32'h2008_0005, 1'b0);
        sendWord(32'h2009_0007, 1'b0);
        waitDone("nom", 12);
        checkVal("nom_error", 32'(error), 32'd0);

        // Reload from DONE with backpressure.
        wBefore = writeCount;
        pulseStart();
        checkVal("reload_cpurst", 32'(cpu_reset), 32'd1);
        checkVal("reload_done", 32'(done), 32'd0);
        sendHeader(16'd1, 1'b1);
        sendWord(32'h0800_0000, 1'b1);
        waitDone("bp", 0);
        checkVal("bp_writes", 32'(writeCount - wBefore), 32'd1);

        // Zero length is rejected.
        wBefore = writeCount;
        pulseStart();
        sendHeader(16'd0, 1'b0);
        checkVal("len0_error", 32'(error), 32'd1);
        checkVal("len0_cpurst", 32'(cpu_reset), 32'd1);
        checkVal("len0_ready", 32'(byte_ready), 32'd0);
        repeat (4) @(negedge clk);
        checkVal("len0_writes", 32'(writeCount - wBefore), 32'd0);

        // One past capacity is rejected.
        pulseStart();
        checkVal("err_clear", 32'(error), 32'd0);
        sendHeader(16'd55, 1'b0);
        checkVal("len55_error", 32'(error), 32'd1);
        checkVal("len55_done", 32'(done), 32'd0);

        // Recovery from ERROR.
        pulseStart();
        checkVal("recover_error", 32'(error), 32'd0);
        sendHeader(16'd1, 1'b0);
        sendWord(32'h2402_000A, 1'b0);
        waitDone("recover", 7);
        checkVal("recover_err_low", 32'(error), 32'd0);

        // Full-capacity image.
        wBefore = writeCount;
        pulseStart();
        sendHeader(16'd54, 1'b0);
        for (int i = 0; i < 54; i++) begin
            sendWord(32'h1000_0001 + 32'(i) * 32'h0101_0101, 1'b0);
        end
        waitDone("max", 2 + 5 * 54);
        checkVal("max_writes", 32'(writeCount - wBefore), 32'd54);
        checkVal("max_last_addr", lastAddr, 32'h0000_00D4);
        repeat (3) @(negedge clk);
        checkVal("max_no_extra", 32'(writeCount - wBefore), 32'd54);

        // Reset in the middle of a three-word load, after six data bytes.
        pulseStart();
        sendHeader(16'd3, 1'b0);
        sendWord(32'hAABB_CCDD, 1'b0);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkReset("midload");
        reset = 1'b0;
        @(negedge clk);
        checkVal("midload_idle", 32'(byte_ready), 32'd0);

        // Fresh load after the abandoned one starts at address 0.
        pulseStart();
        sendHeader(16'd1, 1'b0);
        sendWord(32'h0C00_0010, 1'b0);
        waitDone("fresh", 7);
        checkVal("fresh_addr", lastAddr, 32'h0);

        checkVal("sb_empty", 32'(sbQueue.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mips_program_loader.md
# mips_program_loader

Boot-time loader sitting directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, checks a 16-bit length header, packs big-endian bytes into 32-bit instructions, and writes them to consecutive word-aligned instruction-memory addresses. It holds the core in reset until the image is fully written, then releases it so execution starts at PC 0.

## Interface
- MEMORY_DEPTH, 54, instruction-memory capacity in 32-bit words; largest accepted image length.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE, ERROR.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the word being written; always a multiple of 4.
- imem_wdata  out  32  instruction word being written.
- cpu_reset  out  1  drives the core's reset input; high while loading.
- done  out  1  image loaded, core released.
- error  out  1  header rejected.

## Operation
- Stream format: LEN_HI, LEN_LO (N = 16-bit word count), then 4·N data bytes, each word sent MSB first (first byte goes to bits 31:24).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: byte_ready=0, cpu_reset=1; start -> LEN_HI.
- LEN_HI: accept byte -> len[15:8] -> LEN_LO.
- LEN_LO: accept byte -> len[7:0]. If N==0 or N>MEMORY_DEPTH -> ERROR, otherwise -> DATA with word index 0 and byte index 0.
- DATA: accept bytes and shift them into the packer. On the 4th accepted byte -> WRITE.
- WRITE: byte_ready=0. Drive imem_we=1 for exactly one cycle, with imem_addr = word_index·4 and imem_wdata = packed word. Then increment word_index. If the new index equals N -> DONE, otherwise -> DATA.
- DONE: cpu_reset=0, done=1. start -> LEN_HI, with cpu_reset=1 and done=0 from the next cycle.
- ERROR: error=1, cpu_reset=1, no memory writes. start -> LEN_HI and clears error.
- start outside IDLE/DONE/ERROR is ignored. byte_valid while byte_ready=0 is not consumed; the source must hold the byte.
- Word index is 16 bits. imem_addr = {14'b0, index, 2'b00}; it never exceeds (MEMORY_DEPTH−1)·4.

## Timing
- All outputs are registered. On reset: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, state=IDLE.
- byte_ready is a function of the registered state; it is high exactly in LEN_HI, LEN_LO and DATA.
- With byte_valid held high, each word costs 5 cycles (4 transfer cycles plus 1 WRITE). A full load takes 2 + 5·N cycles after the cycle start is sampled.
- DONE/cpu_reset transition: cpu_reset falls in the cycle after the final imem_we, so the last word is already in memory when the core leaves reset.
- reset mid-load: the load is abandoned, outputs return to reset values within one clock, and partial memory contents are left as written.
- reset and start in the same cycle: reset wins; the state is IDLE.

## Structure
- Shared package mips_loader_pkg holds the state enum (loader_state_t), LEN_BYTES=2, BYTES_PER_WORD=4, and the WORD_ADDR_SHIFT=2 constant, which is also used by the PC logic.
- Sub-module byte_packer: 8-in/32-out shift register with a 2-bit byte counter, shift_en, clear and word_full outputs. The FSM stays in the top module.

## Test plan
- Nominal: N=2, bytes 00 02 20 08 00 05 20 09 00 07 -> imem_we pulses at addr 0x0 with 0x20080005 and at addr 0x4 with 0x20090007. cpu_reset falls the cycle after the 2nd pulse and done=1; 12 cycles after start with valid held high.
- Backpressure: byte_valid toggles every other cycle for N=1 word 0x0800_0000 -> exactly one write at addr 0 with 0x08000000. No byte is lost or duplicated. byte_ready=0 during WRITE.
- Bad length: header 00 00 -> error=1, no imem_we. Header 00 37 (55 > 54) -> error=1. A subsequent start with header 00 01 loads normally and clears error.
- Max image: N=54 -> last write at addr 0xD4, then done=1. No write occurs at 0xD8.
- Reset mid-load: assert reset after 6 data bytes of N=3 -> next cycle has all outputs at reset values and state IDLE. A fresh load then starts writing at addr 0.
- Reload from DONE: start while done=1 -> cpu_reset=1 and done=0 the next cycle. The new image overwrites from addr 0.
